// File: rtl/rs_codeword_collector.sv
`default_nettype none
// ============================================================================
// Module   : rs_codeword_collector
// Purpose  : Collects a stream of GF(2^8) symbols into complete N-symbol
//            Reed-Solomon codewords for the syndrome stage. Two ping-pong
//            buffers let one codeword fill while the other is presented.
//            Frame 0th symbol lands in the MSBs, last symbol in the LSBs.
// Ports    :
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   sym_in     in   received symbol
//   sym_valid  in   sym_in valid this cycle
//   sym_sop    in   sym_in is first symbol of a codeword (with sym_valid)
//   sym_ready  out  block accepts a symbol this cycle (registered)
//   cw_out     out  assembled codeword (N*SYMBOL_WIDTH bits)
//   cw_valid   out  cw_out holds a complete codeword
//   cw_ready   in   downstream accepts cw_out
//   err_short  out  1-cycle pulse: partial frame discarded by early sop
//   err_nosop  out  1-cycle pulse: symbol dropped, no frame open
// Notes    : N must be at least 2.
// Revision : 1.0 - initial release
// ============================================================================
module rs_codeword_collector #(
  parameter int N            = 18,
  parameter int SYMBOL_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [SYMBOL_WIDTH-1:0]      sym_in,
  input  logic                         sym_valid,
  input  logic                         sym_sop,
  output logic                         sym_ready,
  output logic [N*SYMBOL_WIDTH-1:0]    cw_out,
  output logic                         cw_valid,
  input  logic                         cw_ready,
  output logic                         err_short,
  output logic                         err_nosop
);

  localparam int                c_cnt_w    = (N > 1) ? $clog2(N) : 1;
  localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(N - 1);
  localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);

  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'd0,
    BUF_FILLING = 2'd1,
    BUF_FULL    = 2'd2
  } buf_state_t;

  // Per-buffer state and storage. Slot s holds the symbol that ends up at
  // cw_out[s*SYMBOL_WIDTH +: SYMBOL_WIDTH], so frame symbol k goes to slot N-1-k.
  buf_state_t                r_state     [2];
  buf_state_t                w_state_nxt [2];
  logic [SYMBOL_WIDTH-1:0]   r_sym       [2][N];

  logic                      r_wsel, w_wsel_nxt;
  logic                      r_rsel, w_rsel_nxt;
  logic [c_cnt_w-1:0]        r_cnt, w_cnt_nxt;
  logic                      r_sym_ready, w_sym_ready_nxt;
  logic                      r_err_short, w_err_short_nxt;
  logic                      r_err_nosop, w_err_nosop_nxt;

  logic                      w_in_xfer;
  logic                      w_out_xfer;
  logic                      w_wr_en;
  logic [c_cnt_w-1:0]        w_slot;

  assign w_in_xfer  = sym_valid & r_sym_ready;
  assign w_out_xfer = cw_valid & cw_ready;

  // --------------------------------------------------------------------------
  // Next-state logic for the buffer states, selects, counter and flags.
  // The read side and the fill side always touch different buffers when both
  // are active: a buffer being filled is never FULL, so it cannot be presenting.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_wsel_nxt      = r_wsel;
    w_rsel_nxt      = r_rsel;
    w_cnt_nxt       = r_cnt;
    w_err_short_nxt = 1'b0;
    w_err_nosop_nxt = 1'b0;
    w_wr_en         = 1'b0;
    w_slot          = c_last_idx - r_cnt;

    if (w_out_xfer) begin
      w_state_nxt[r_rsel] = BUF_EMPTY;
      w_rsel_nxt          = ~r_rsel;
    end

    if (w_in_xfer) begin
      if (sym_sop) begin
        // Start (or restart) a frame in the current fill buffer.
        w_wr_en              = 1'b1;
        w_slot               = c_last_idx;
        w_state_nxt[r_wsel]  = BUF_FILLING;
        w_cnt_nxt            = c_one;
        w_err_short_nxt      = (r_cnt != '0);
      end else if (r_cnt == '0) begin
        // No frame open: the symbol is dropped.
        w_err_nosop_nxt = 1'b1;
      end else begin
        w_wr_en = 1'b1;
        if (r_cnt == c_last_idx) begin
          w_state_nxt[r_wsel] = BUF_FULL;
          w_wsel_nxt          = ~r_wsel;
          w_cnt_nxt           = '0;
        end else begin
          w_state_nxt[r_wsel] = BUF_FILLING;
          w_cnt_nxt           = r_cnt + c_one;
        end
      end
    end

    // Ready for next cycle is decided from the state the buffers will be in,
    // so the output never depends combinationally on cw_ready or sym_valid.
    w_sym_ready_nxt = (w_state_nxt[w_wsel_nxt] != BUF_FULL);
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state[0]  <= BUF_EMPTY;
      r_state[1]  <= BUF_EMPTY;
      r_wsel      <= 1'b0;
      r_rsel      <= 1'b0;
      r_cnt       <= '0;
      r_sym_ready <= 1'b0;
      r_err_short <= 1'b0;
      r_err_nosop <= 1'b0;
    end else begin
      r_state[0]  <= w_state_nxt[0];
      r_state[1]  <= w_state_nxt[1];
      r_wsel      <= w_wsel_nxt;
      r_rsel      <= w_rsel_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sym_ready <= w_sym_ready_nxt;
      r_err_short <= w_err_short_nxt;
      r_err_nosop <= w_err_nosop_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Symbol storage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < N; s++) begin
          r_sym[b][s] <= '0;
        end
      end
    end else if (w_wr_en) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < N; s++) begin
          if ((r_wsel == b[0]) && (w_slot == c_cnt_w'(s))) begin
            r_sym[b][s] <= sym_in;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  generate
    for (genvar s = 0; s < N; s++) begin : g_pack
      assign cw_out[s*SYMBOL_WIDTH +: SYMBOL_WIDTH] = r_sym[r_rsel][s];
    end
  endgenerate

  assign cw_valid  = (r_state[r_rsel] == BUF_FULL);
  assign sym_ready = r_sym_ready;
  assign err_short = r_err_short;
  assign err_nosop = r_err_nosop;

endmodule
`default_nettype wire

// File: tb/tb_rs_codeword_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_codeword_collector
// Purpose  : Scoreboard bench for rs_codeword_collector. A reference model
//            reassembles frames from accepted symbols into expected codewords;
//            a monitor pops and compares on every output transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_codeword_collector;

  localparam int N  = 18;
  localparam int W  = 8;
  localparam int CW = N * W;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic [W-1:0]  sym_in    = '0;
  logic          sym_valid = 1'b0;
  logic          sym_sop   = 1'b0;
  logic          cw_ready  = 1'b0;
  logic          sym_ready;
  logic [CW-1:0] cw_out;
  logic          cw_valid;
  logic          err_short;
  logic          err_nosop;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  logic [CW-1:0] exp_q   [$];
  logic [W-1:0]  partial [$];
  logic [CW-1:0] m_cw;
  logic          exp_short = 1'b0;
  logic          exp_nosop = 1'b0;

  // monitor state
  int            held_at_edge = 0;
  logic          edge_ok      = 1'b0;
  logic          have_prev    = 1'b0;
  logic [CW-1:0] prev_out     = '0;
  logic [CW-1:0] exp_cw;
  int            n_out   = 0;
  int            n_short = 0;
  int            n_nosop = 0;
  int            n_vcyc  = 0;

  logic          gaps      = 1'b0;
  logic          rand_done = 1'b0;

  rs_codeword_collector #(.N(N), .SYMBOL_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .sym_sop   (sym_sop),
    .sym_ready (sym_ready),
    .cw_out    (cw_out),
    .cw_valid  (cw_valid),
    .cw_ready  (cw_ready),
    .err_short (err_short),
    .err_nosop (err_nosop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Codewords held inside the DUT during the cycle that starts at this edge.
  always @(posedge clk) begin
    edge_ok      = rst_n;
    held_at_edge = exp_q.size();
  end

  // Reference model: frames rebuilt from accepted symbols.
  always @(negedge clk) begin
    if (!rst_n) begin
      partial.delete();
      exp_q.delete();
      exp_short = 1'b0;
      exp_nosop = 1'b0;
    end else begin
      chk("err_short", {{(CW-1){1'b0}}, err_short}, {{(CW-1){1'b0}}, exp_short});
      chk("err_nosop", {{(CW-1){1'b0}}, err_nosop}, {{(CW-1){1'b0}}, exp_nosop});
      exp_short = 1'b0;
      exp_nosop = 1'b0;
      if (sym_valid && sym_ready) begin
        if (sym_sop) begin
          if (partial.size() != 0) exp_short = 1'b1;
          partial.delete();
          partial.push_back(sym_in);
        end else if (partial.size() == 0) begin
          exp_nosop = 1'b1;
        end else begin
          partial.push_back(sym_in);
        end
        if (partial.size() == N) begin
          m_cw = '0;
          for (int k = 0; k < N; k++) m_cw[(N-k)*W-1 -: W] = partial[k];
          exp_q.push_back(m_cw);
          partial.delete();
        end
      end
    end
  end

  // Monitor: output transfers, hold-under-backpressure, ready rule.
  always @(negedge clk) begin
    if (!rst_n) begin
      have_prev = 1'b0;
    end else begin
      n_short += int'(err_short);
      n_nosop += int'(err_nosop);
      n_vcyc  += int'(cw_valid);
      if (have_prev) begin
        chk("hold_valid", {{(CW-1){1'b0}}, cw_valid}, {{(CW-1){1'b0}}, 1'b1});
        chk("hold_data", cw_out, prev_out);
      end
      have_prev = cw_valid && !cw_ready;
      prev_out  = cw_out;
      if (cw_valid && cw_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL cw_unexpected: got %0h required none (t=%0t)", cw_out, $time);
        end else begin
          exp_cw = exp_q.pop_front();
          chk("cw_out", cw_out, exp_cw);
        end
      end
      if (edge_ok) begin
        chk("sym_ready", {{(CW-1){1'b0}}, sym_ready},
            {{(CW-1){1'b0}}, (held_at_edge < 2)});
      end
    end
  end

  task automatic send(input logic [W-1:0] s, input logic sop);
    int  w;
    logic ok;
    while (gaps && ($urandom % 4 == 0)) begin
      sym_valid = 1'b0;
      @(posedge clk); #1;
    end
    sym_in    = s;
    sym_sop   = sop;
    sym_valid = 1'b1;
    w = 0;
    ok = 1'b0;
    while (!ok) begin
      @(negedge clk);
      ok = sym_ready;
      @(posedge clk); #1;
      w++;
      if (!ok && w > 500) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: got no acceptance required acceptance (t=%0t)", $time);
        ok = 1'b1;
      end
    end
    sym_valid = 1'b0;
    sym_sop   = 1'b0;
  endtask

  task automatic send_frame();
    for (int k = 0; k < N; k++) send(W'($urandom), k == 0);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 1000) begin
      @(posedge clk); #1;
      w++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_cw_valid",  {{(CW-1){1'b0}}, cw_valid},  '0);
    chk("rst_sym_ready", {{(CW-1){1'b0}}, sym_ready}, '0);
    chk("rst_err_short", {{(CW-1){1'b0}}, err_short}, '0);
    chk("rst_err_nosop", {{(CW-1){1'b0}}, err_nosop}, '0);
    chk("rst_cw_out",    cw_out, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", {{(CW-1){1'b0}}, sym_ready}, {{(CW-1){1'b0}}, 1'b1});
    chk("post_rst_valid", {{(CW-1){1'b0}}, cw_valid},  '0);
  endtask

  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: got timeout required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0, o0, v0, r, len;
    do_reset();

    // Counting frame 0x01..0x12
    cw_ready = 1'b1;
    for (int k = 0; k < N; k++) send(W'(k + 1), k == 0);
    chk("lat_valid", {{(CW-1){1'b0}}, cw_valid}, {{(CW-1){1'b0}}, 1'b1});
    chk("first_sym", {{(CW-W){1'b0}}, cw_out[143:136]}, {{(CW-W){1'b0}}, 8'h01});
    chk("last_sym",  {{(CW-W){1'b0}}, cw_out[7:0]},     {{(CW-W){1'b0}}, 8'h12});
    drain();

    // Backpressure: two frames held, third stalls
    cw_ready = 1'b0;
    o0 = n_out;
    send_frame();
    send_frame();
    chk("both_full_ready", {{(CW-1){1'b0}}, sym_ready}, '0);
    chk("both_full_valid", {{(CW-1){1'b0}}, cw_valid}, {{(CW-1){1'b0}}, 1'b1});
    fork
      begin repeat (4) @(posedge clk); #1; cw_ready = 1'b1; end
      send_frame();
    join
    drain();
    chk("bp_count", CW'(n_out - o0), CW'(3));

    // Short frame followed by a full frame
    s0 = n_short; o0 = n_out;
    for (int k = 0; k < 10; k++) send(W'($urandom), k == 0);
    send_frame();
    drain();
    chk("short_pulses", CW'(n_short - s0), CW'(1));
    chk("short_out",    CW'(n_out - o0),   CW'(1));

    // Symbols with no frame open
    do_reset();
    s0 = n_nosop; v0 = n_vcyc;
    for (int k = 0; k < 5; k++) send(W'($urandom), 1'b0);
    repeat (3) @(posedge clk); #1;
    chk("nosop_pulses", CW'(n_nosop - s0), CW'(5));
    chk("nosop_valid",  CW'(n_vcyc - v0),  CW'(0));
    o0 = n_out;
    send_frame();
    drain();
    chk("nosop_then_frame", CW'(n_out - o0), CW'(1));

    // Reset mid-frame with a codeword held
    cw_ready = 1'b0;
    send_frame();
    for (int k = 0; k < 9; k++) send(W'($urandom), k == 0);
    chk("held_before_rst", {{(CW-1){1'b0}}, cw_valid}, {{(CW-1){1'b0}}, 1'b1});
    do_reset();
    cw_ready = 1'b1;
    o0 = n_out;
    send_frame();
    drain();
    chk("after_rst_out", CW'(n_out - o0), CW'(1));

    // Randomized traffic with stalls on both sides
    gaps = 1'b1;
    rand_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 1000; f++) begin
          r = int'($urandom % 40);
          if (r == 0) begin
            len = 1 + int'($urandom % (N - 1));
            for (int k = 0; k < len; k++) send(W'($urandom), k == 0);
          end else if (r == 1) begin
            len = 1 + int'($urandom % 3);
            for (int k = 0; k < len; k++) send(W'($urandom), 1'b0);
          end
          send_frame();
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          cw_ready = ($urandom % 10) < 6;
        end
      end
    join
    gaps = 1'b0;
    cw_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
